// File: rtl/rr_bank_arbiter.sv
// rr_bank_arbiter: shares one single-port PLM bank among NCONSUMERS requesters.
// The arbiter grants one request per cycle in round-robin order, starting from a
// pivot. A tag pipeline, READ_LATENCY stages deep, follows each granted read so
// that the read data returns only to the consumer that issued the read.
//
// Handshake: each requests[i] entry is {addr, value, wr, valid} with valid at
// bit 0. A consumer holds its request stable until grants[i] is high in the
// same cycle. In that cycle the PLM samples plm_input. On the next cycle the
// consumer may present a new request or drop valid. A grant is never revoked.
// A read's data comes back exactly READ_LATENCY cycles after its grant, for one
// cycle, with resp_valid one-hot on the owner. Writes produce no response.
module rr_bank_arbiter #(
  parameter int ADDR_WIDTH   = 4,
  parameter int VALUE_WIDTH  = 8,
  parameter int NCONSUMERS   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH+VALUE_WIDTH+1:0] requests [NCONSUMERS],
  output logic [NCONSUMERS-1:0]             grants,
  output logic [ADDR_WIDTH+VALUE_WIDTH:0]   plm_input,
  input  logic [VALUE_WIDTH-1:0]            plm_output,
  output logic [NCONSUMERS-1:0]             resp_valid,
  output logic [VALUE_WIDTH-1:0]            resp_value
);

  localparam int REQ_WIDTH = ADDR_WIDTH + VALUE_WIDTH + 2;
  localparam int ID_WIDTH  = ($clog2(NCONSUMERS) > 1) ? $clog2(NCONSUMERS) : 1;

  logic [ID_WIDTH-1:0]   pivot;
  logic [NCONSUMERS-1:0] valid_vec;
  logic                  found;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH:0]     scan_sum;
  logic [REQ_WIDTH-1:0]  win_req;
  logic                  grant_any;
  logic                  tag_valid [READ_LATENCY];
  logic [ID_WIDTH-1:0]   tag_id    [READ_LATENCY];

  // Collect the valid bit of every consumer into one vector.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NCONSUMERS; i++) begin
      valid_vec[i] = requests[i][0];
    end
  end

  // Scan from the pivot upward with an explicit wrap. The first valid consumer wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    for (int k = 0; k < NCONSUMERS; k++) begin
      scan_sum = {1'b0, pivot} + (ID_WIDTH+1)'(k);
      if (scan_sum >= (ID_WIDTH+1)'(NCONSUMERS)) begin
        scan_sum = scan_sum - (ID_WIDTH+1)'(NCONSUMERS);
      end
      if (!found && valid_vec[scan_sum[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = scan_sum[ID_WIDTH-1:0];
      end
    end
  end

  // Drive the grant and the PLM request. Both are forced to zero while reset is held.
  always_comb begin
    win_req   = requests[winner];
    grant_any = found && !reset;
    grants    = grant_any ? (NCONSUMERS'(1) << winner) : '0;
    plm_input = grant_any ? win_req[REQ_WIDTH-1:1] : '0;
  end

  // On a grant, advance the pivot to one past the winner, wrapping to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pivot <= '0;
    end else if (grant_any) begin
      pivot <= (winner == ID_WIDTH'(NCONSUMERS - 1)) ? '0 : winner + ID_WIDTH'(1);
    end
  end

  // Tag pipeline. A granted read enters stage 0. Every stage shifts forward each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        tag_valid[s] <= 1'b0;
        tag_id[s]    <= '0;
      end
    end else begin
      tag_valid[0] <= grant_any && !win_req[1];
      tag_id[0]    <= winner;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  // The last stage routes the PLM read data to its owner.
  always_comb begin
    resp_valid = tag_valid[READ_LATENCY-1] ? (NCONSUMERS'(1) << tag_id[READ_LATENCY-1]) : '0;
    resp_value = tag_valid[READ_LATENCY-1] ? plm_output : '0;
  end

endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Directed bench for rr_bank_arbiter. Three instances cover these configurations:
//   a: 4 consumers, latency 1, with a small PLM memory model
//   b: 3 consumers, latency 3, where the PLM echoes the read address
//   c: 4 consumers, latency 2, where the PLM echoes the read address
module tb_rr_bank_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- instance a: N=4, L=1 ----------------
  logic        rst_a;
  logic [13:0] req_a [4];
  logic [3:0]  grants_a, resp_valid_a;
  logic [12:0] plm_in_a;
  logic [7:0]  plm_out_a, resp_value_a;
  logic [7:0]  mem_a [16];

  rr_bank_arbiter #(.ADDR_WIDTH(4), .VALUE_WIDTH(8), .NCONSUMERS(4), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a), .requests(req_a), .grants(grants_a), .plm_input(plm_in_a),
    .plm_output(plm_out_a), .resp_valid(resp_valid_a), .resp_value(resp_value_a)
  );

  // PLM model: a read-first memory with one-cycle latency, preloaded with 0x10+addr.
  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 8'(16 + i);
    end else if (plm_in_a[0]) begin
      mem_a[plm_in_a[12:9]] <= plm_in_a[8:1];
    end
    plm_out_a <= mem_a[plm_in_a[12:9]];
  end

  // ---------------- instance b: N=3, L=3 ----------------
  logic        rst_b;
  logic [13:0] req_b [3];
  logic [2:0]  grants_b, resp_valid_b;
  logic [12:0] plm_in_b;
  logic [7:0]  plm_out_b, resp_value_b, b_d1, b_d2;

  rr_bank_arbiter #(.ADDR_WIDTH(4), .VALUE_WIDTH(8), .NCONSUMERS(3), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_b), .requests(req_b), .grants(grants_b), .plm_input(plm_in_b),
    .plm_output(plm_out_b), .resp_valid(resp_valid_b), .resp_value(resp_value_b)
  );

  always @(posedge clk) begin
    b_d1      <= {4'h0, plm_in_b[12:9]};
    b_d2      <= b_d1;
    plm_out_b <= b_d2;
  end

  // ---------------- instance c: N=4, L=2 ----------------
  logic        rst_c;
  logic [13:0] req_c [4];
  logic [3:0]  grants_c, resp_valid_c;
  logic [12:0] plm_in_c;
  logic [7:0]  plm_out_c, resp_value_c, c_d1;

  rr_bank_arbiter #(.ADDR_WIDTH(4), .VALUE_WIDTH(8), .NCONSUMERS(4), .READ_LATENCY(2)) dut_c (
    .clk(clk), .reset(rst_c), .requests(req_c), .grants(grants_c), .plm_input(plm_in_c),
    .plm_output(plm_out_c), .resp_valid(resp_valid_c), .resp_value(resp_value_c)
  );

  always @(posedge clk) begin
    c_d1      <= {4'h0, plm_in_c[12:9]};
    plm_out_c <= c_d1;
  end

  // ---------------- helpers ----------------
  function automatic logic [13:0] rd(input logic [3:0] a);
    return {a, 8'h00, 1'b0, 1'b1};
  endfunction

  function automatic logic [13:0] wrq(input logic [3:0] a, input logic [7:0] v);
    return {a, v, 1'b1, 1'b1};
  endfunction

  localparam logic [13:0] IDLE = 14'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_cycle(input logic rst, input logic [13:0] r0, r1, r2, r3, input string tag,
                         input logic [3:0] g, input logic [12:0] p,
                         input logic [3:0] rv, input logic [7:0] val);
    @(negedge clk);
    rst_a = rst;
    req_a[0] = r0; req_a[1] = r1; req_a[2] = r2; req_a[3] = r3;
    #1;
    chk({tag, "_grants"}, 32'(grants_a), 32'(g));
    chk({tag, "_plm_input"}, 32'(plm_in_a), 32'(p));
    chk({tag, "_resp_valid"}, 32'(resp_valid_a), 32'(rv));
    chk({tag, "_resp_value"}, 32'(resp_value_a), 32'(val));
  endtask

  task automatic b_cycle(input logic rst, input logic [13:0] r0, r1, r2, input string tag,
                         input logic [2:0] g, input logic [12:0] p,
                         input logic [2:0] rv, input logic [7:0] val);
    @(negedge clk);
    rst_b = rst;
    req_b[0] = r0; req_b[1] = r1; req_b[2] = r2;
    #1;
    chk({tag, "_grants"}, 32'(grants_b), 32'(g));
    chk({tag, "_plm_input"}, 32'(plm_in_b), 32'(p));
    chk({tag, "_resp_valid"}, 32'(resp_valid_b), 32'(rv));
    chk({tag, "_resp_value"}, 32'(resp_value_b), 32'(val));
  endtask

  task automatic c_cycle(input logic rst, input logic [13:0] r0, r1, r2, r3, input string tag,
                         input logic [3:0] g, input logic [12:0] p,
                         input logic [3:0] rv, input logic [7:0] val);
    @(negedge clk);
    rst_c = rst;
    req_c[0] = r0; req_c[1] = r1; req_c[2] = r2; req_c[3] = r3;
    #1;
    chk({tag, "_grants"}, 32'(grants_c), 32'(g));
    chk({tag, "_plm_input"}, 32'(plm_in_c), 32'(p));
    chk({tag, "_resp_valid"}, 32'(resp_valid_c), 32'(rv));
    chk({tag, "_resp_value"}, 32'(resp_value_c), 32'(val));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0]  exp_g  [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [12:0] exp_p  [8] = '{13'h000, 13'h200, 13'h400, 13'h600, 13'h000, 13'h200, 13'h400, 13'h600};
    logic [3:0]  exp_rv [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    logic [7:0]  exp_v  [8] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int i = 0; i < 4; i++) begin req_a[i] = IDLE; req_c[i] = IDLE; end
    for (int i = 0; i < 3; i++) req_b[i] = IDLE;
    repeat (2) @(negedge clk);

    // Reset state: everyone is valid, but reset forces all outputs to zero.
    a_cycle(1'b1, rd(0), rd(1), rd(2), rd(3), "a_reset0", 4'h0, 13'h0, 4'h0, 8'h00);
    a_cycle(1'b1, rd(0), rd(1), rd(2), rd(3), "a_reset1", 4'h0, 13'h0, 4'h0, 8'h00);

    // Full contention for 8 cycles: rotation 0..3 twice, responses one cycle later.
    for (int k = 0; k < 8; k++) begin
      a_cycle(1'b0, rd(0), rd(1), rd(2), rd(3), $sformatf("a_full%0d", k),
              exp_g[k], exp_p[k], exp_rv[k], exp_v[k]);
    end
    a_cycle(1'b0, IDLE, IDLE, IDLE, IDLE, "a_drain", 4'h0, 13'h000, 4'h8, 8'h13);

    // Pivot skip and wrap.
    a_cycle(1'b0, IDLE, IDLE, rd(2), IDLE,   "a_skip_c2",   4'h4, 13'h400, 4'h0, 8'h00);
    a_cycle(1'b0, IDLE, rd(1), IDLE, rd(3),  "a_skip_c3",   4'h8, 13'h600, 4'h4, 8'h12);
    a_cycle(1'b0, IDLE, rd(1), IDLE, IDLE,   "a_wrap_c1",   4'h2, 13'h200, 4'h8, 8'h13);
    a_cycle(1'b0, rd(0), rd(1), IDLE, rd(3), "a_pivot2",    4'h8, 13'h600, 4'h2, 8'h11);
    a_cycle(1'b0, rd(0), rd(1), IDLE, IDLE,  "a_pivot0",    4'h1, 13'h000, 4'h8, 8'h13);

    // Write then read back through the memory model.
    a_cycle(1'b0, IDLE, wrq(5, 8'hA5), IDLE, IDLE, "a_write", 4'h2, 13'hB4B, 4'h1, 8'h10);
    a_cycle(1'b0, rd(5), IDLE, IDLE, IDLE,   "a_read5",     4'h1, 13'hA00, 4'h0, 8'h00);
    a_cycle(1'b0, IDLE, IDLE, IDLE, IDLE,    "a_resp5",     4'h0, 13'h000, 4'h1, 8'hA5);
    a_cycle(1'b0, IDLE, IDLE, IDLE, IDLE,    "a_quiet",     4'h0, 13'h000, 4'h0, 8'h00);

    // Non-power-of-two wrap, 3 consumers with latency 3. Consumer i reads addr i+4.
    b_cycle(1'b0, rd(4), rd(5), rd(6), "b_c0", 3'h1, 13'h800, 3'h0, 8'h00);
    b_cycle(1'b0, rd(4), rd(5), rd(6), "b_c1", 3'h2, 13'hA00, 3'h0, 8'h00);
    b_cycle(1'b0, rd(4), rd(5), rd(6), "b_c2", 3'h4, 13'hC00, 3'h0, 8'h00);
    b_cycle(1'b0, rd(4), rd(5), rd(6), "b_c3", 3'h1, 13'h800, 3'h1, 8'h04);
    b_cycle(1'b0, rd(4), rd(5), rd(6), "b_c4", 3'h2, 13'hA00, 3'h2, 8'h05);
    b_cycle(1'b0, rd(4), rd(5), rd(6), "b_c5", 3'h4, 13'hC00, 3'h4, 8'h06);
    b_cycle(1'b0, IDLE, IDLE, IDLE,    "b_c6", 3'h0, 13'h000, 3'h1, 8'h04);
    b_cycle(1'b0, IDLE, IDLE, IDLE,    "b_c7", 3'h0, 13'h000, 3'h2, 8'h05);
    b_cycle(1'b0, IDLE, IDLE, IDLE,    "b_c8", 3'h0, 13'h000, 3'h4, 8'h06);
    b_cycle(1'b0, IDLE, IDLE, IDLE,    "b_c9", 3'h0, 13'h000, 3'h0, 8'h00);

    // Reset during operation, latency 2.
    c_cycle(1'b0, IDLE, IDLE, IDLE, rd(9),    "c_grant3",  4'h8, 13'h1200, 4'h0, 8'h00);
    c_cycle(1'b1, rd(9), rd(9), rd(9), rd(9), "c_reset1",  4'h0, 13'h0000, 4'h0, 8'h00);
    c_cycle(1'b0, IDLE, IDLE, IDLE, IDLE,     "c_dropped", 4'h0, 13'h0000, 4'h0, 8'h00);
    c_cycle(1'b0, IDLE, rd(9), IDLE, IDLE,    "c_grant1",  4'h2, 13'h1200, 4'h0, 8'h00);
    c_cycle(1'b1, rd(9), rd(9), rd(9), rd(9), "c_reset2",  4'h0, 13'h0000, 4'h0, 8'h00);
    c_cycle(1'b0, rd(9), rd(9), rd(9), rd(9), "c_pivot0",  4'h1, 13'h1200, 4'h0, 8'h00);
    c_cycle(1'b0, IDLE, IDLE, IDLE, IDLE,     "c_wait",    4'h0, 13'h0000, 4'h0, 8'h00);
    c_cycle(1'b0, IDLE, IDLE, IDLE, IDLE,     "c_resp0",   4'h0, 13'h0000, 4'h1, 8'h09);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
